// File: rtl/load_store_unit.sv
// load_store_unit: sequences one CPU load/store at a time onto a byte-addressable memory port.
// Build option MEM_MISALIGN_SPLIT_EN: split misaligned accesses into byte beats instead of rejecting them.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_error,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [1:0]               mem_size,
    output logic                     mem_write_enable,
    output logic [31:0]              mem_write_value,
    input  logic [31:0]              mem_read_value
);
    // state  | meaning
    // IDLE   | req_ready high, waiting for a request
    // ACCESS | memory beat(s) in flight; rejected requests also pass through here once
    // RESP   | resp_valid pulse
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    logic [1:0]               state_q, state_d;
    logic                     write_q, write_d;
    logic [1:0]               size_q, size_d;
    logic                     unsigned_q, unsigned_d;
    logic                     error_q, error_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [31:0]              resp_rdata_q, resp_rdata_d;
    logic                     resp_error_q, resp_error_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [1:0]               mem_size_q, mem_size_d;
    logic                     mem_write_enable_q, mem_write_enable_d;
    logic [31:0]              mem_write_value_q, mem_write_value_d;
`ifdef MEM_MISALIGN_SPLIT_EN
    logic                     misaligned_q, misaligned_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              rdata_q, rdata_d;
`endif

    logic        req_misaligned;
    logic        access_done;
    logic [31:0] load_data;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_mask = 32'h0000_00FF;
            SIZE_HALF: size_mask = 32'h0000_FFFF;
            default:   size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic is_unsigned);
        case (size)
            SIZE_BYTE: extend_load = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SIZE_HALF: extend_load = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default:   extend_load = raw;
        endcase
    endfunction

    always_comb begin
        case (req_size)
            SIZE_HALF: req_misaligned = req_address[0];
            SIZE_WORD: req_misaligned = (req_address[1:0] != 2'b00);
            default:   req_misaligned = 1'b0;
        endcase
    end

`ifdef MEM_MISALIGN_SPLIT_EN
    assign access_done = !misaligned_q ||
                         (byte_idx_q == ((size_q == SIZE_HALF) ? 2'd1 : 2'd3));

    // Split loads collect one byte per beat into the assembly register.
    always_comb begin
        load_data = mem_read_value;
        if (misaligned_q) begin
            load_data = rdata_q;
            load_data[{byte_idx_q, 3'b000} +: 8] = mem_read_value[7:0];
        end
    end
`else
    assign access_done = 1'b1;
    assign load_data   = mem_read_value;
`endif

    always_comb begin
        state_d            = state_q;
        write_d            = write_q;
        size_d             = size_q;
        unsigned_d         = unsigned_q;
        error_d            = error_q;
        resp_valid_d       = 1'b0;
        resp_rdata_d       = resp_rdata_q;
        resp_error_d       = resp_error_q;
        mem_address_d      = mem_address_q;
        mem_size_d         = mem_size_q;
        mem_write_enable_d = mem_write_enable_q;
        mem_write_value_d  = mem_write_value_q;
`ifdef MEM_MISALIGN_SPLIT_EN
        misaligned_d       = misaligned_q;
        byte_idx_d         = byte_idx_q;
        wdata_d            = wdata_q;
        rdata_d            = rdata_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    state_d    = ST_ACCESS;
`ifdef MEM_MISALIGN_SPLIT_EN
                    wdata_d      = req_wdata;
                    rdata_d      = '0;
                    byte_idx_d   = 2'd0;
                    misaligned_d = 1'b0;
                    if (req_size == SIZE_ILLEGAL) begin
                        error_d = 1'b1;
                    end else begin
                        error_d            = 1'b0;
                        misaligned_d       = req_misaligned;
                        mem_address_d      = req_address;
                        mem_write_enable_d = req_write;
                        if (req_misaligned) begin
                            mem_size_d        = SIZE_BYTE;
                            mem_write_value_d = {24'h0, req_wdata[7:0]};
                        end else begin
                            mem_size_d        = req_size;
                            mem_write_value_d = req_wdata & size_mask(req_size);
                        end
                    end
`else
                    if (req_size == SIZE_ILLEGAL || req_misaligned) begin
                        error_d = 1'b1;
                    end else begin
                        error_d            = 1'b0;
                        mem_address_d      = req_address;
                        mem_size_d         = req_size;
                        mem_write_enable_d = req_write;
                        mem_write_value_d  = req_wdata & size_mask(req_size);
                    end
`endif
                end
            end

            // Rejected requests spend one quiet ACCESS cycle so every single-beat response
            // lands at the same latency; the memory port is left untouched for them.
            ST_ACCESS: begin
`ifdef MEM_MISALIGN_SPLIT_EN
                rdata_d = load_data;
`endif
                if (error_q || access_done) begin
                    state_d            = ST_RESP;
                    mem_write_enable_d = 1'b0;
                    resp_valid_d       = 1'b1;
                    resp_error_d       = error_q;
                    resp_rdata_d       = (write_q || error_q) ? 32'h0
                                       : extend_load(load_data, size_q, unsigned_q);
                end
`ifdef MEM_MISALIGN_SPLIT_EN
                else begin
                    byte_idx_d        = byte_idx_q + 2'd1;
                    mem_address_d     = mem_address_q + ADDRESS_WIDTH'(1);
                    mem_write_value_d = {24'h0, wdata_q[{byte_idx_d, 3'b000} +: 8]};
                end
`endif
            end

            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_rdata_d = 32'h0;
                resp_error_d = 1'b0;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            write_q            <= 1'b0;
            size_q             <= SIZE_BYTE;
            unsigned_q         <= 1'b0;
            error_q            <= 1'b0;
            resp_valid_q       <= 1'b0;
            resp_rdata_q       <= 32'h0;
            resp_error_q       <= 1'b0;
            mem_address_q      <= '0;
            mem_size_q         <= SIZE_WORD;
            mem_write_enable_q <= 1'b0;
            mem_write_value_q  <= 32'h0;
`ifdef MEM_MISALIGN_SPLIT_EN
            misaligned_q       <= 1'b0;
            byte_idx_q         <= 2'd0;
            wdata_q            <= 32'h0;
            rdata_q            <= 32'h0;
`endif
        end else begin
            state_q            <= state_d;
            write_q            <= write_d;
            size_q             <= size_d;
            unsigned_q         <= unsigned_d;
            error_q            <= error_d;
            resp_valid_q       <= resp_valid_d;
            resp_rdata_q       <= resp_rdata_d;
            resp_error_q       <= resp_error_d;
            mem_address_q      <= mem_address_d;
            mem_size_q         <= mem_size_d;
            mem_write_enable_q <= mem_write_enable_d;
            mem_write_value_q  <= mem_write_value_d;
`ifdef MEM_MISALIGN_SPLIT_EN
            misaligned_q       <= misaligned_d;
            byte_idx_q         <= byte_idx_d;
            wdata_q            <= wdata_d;
            rdata_q            <= rdata_d;
`endif
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;
    assign mem_address      = mem_address_q;
    assign mem_size         = mem_size_q;
    assign mem_write_enable = mem_write_enable_q;
    assign mem_write_value  = mem_write_value_q;

endmodule
